// File: rtl/snn_timestep_controller_pkg.sv
// Shared definitions for the SNN timestep controller: FSM state encoding and
// the default drain depth of the downstream threshold/accumulator pipeline.
package snn_timestep_controller_pkg;

    localparam int DEFAULT_DRAIN_CYCLES = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

endpackage

// File: rtl/snn_timestep_controller.sv
// Sequences one SNN inference: clear spike accumulators, walk the timesteps
// with upstream, drain the activation pipeline, then hand the result over.
module snn_timestep_controller
    import snn_timestep_controller_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int TS_WIDTH     = 8,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic        [TS_WIDTH-1:0]   num_timesteps,
    input  logic signed [DATA_WIDTH-1:0] cfg_threshold,
    output logic signed [DATA_WIDTH-1:0] threshold,
    output logic                         reset_accumulated_spikes,
    output logic                         ts_req,
    input  logic                         ts_ack,
    output logic        [TS_WIDTH-1:0]   ts_index,
    output logic                         busy,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic                         done
);

    localparam int DRAIN_CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t                         state_q, state_d;
    logic        [TS_WIDTH-1:0]     num_ts_q, num_ts_d;
    logic        [TS_WIDTH-1:0]     ts_index_q, ts_index_d;
    logic signed [DATA_WIDTH-1:0]   threshold_q, threshold_d;
    logic        [DRAIN_CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic                           done_q, done_d;

    logic last_index;
    logic drain_last;

    assign last_index = (ts_index_q == (num_ts_q - TS_WIDTH'(1)));
    assign drain_last = (drain_cnt_q == DRAIN_CNT_W'(DRAIN_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            num_ts_q    <= '0;
            ts_index_q  <= '0;
            threshold_q <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            num_ts_q    <= num_ts_d;
            ts_index_q  <= ts_index_d;
            threshold_q <= threshold_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    // ts_req is high for the whole of RUN, so ts_ack alone marks a handshake there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR:  state_d = (num_ts_q == '0) ? S_DRAIN : S_RUN;
            S_RUN:    if (ts_ack && last_index) state_d = S_DRAIN;
            S_DRAIN:  if (drain_last) state_d = S_OUTPUT;
            S_OUTPUT: if (result_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        num_ts_d    = num_ts_q;
        ts_index_d  = ts_index_q;
        threshold_d = threshold_q;
        drain_cnt_d = '0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_ts_d    = num_timesteps;
                    threshold_d = cfg_threshold;
                    ts_index_d  = '0;
                end
            end
            S_RUN:    if (ts_ack) ts_index_d = ts_index_q + TS_WIDTH'(1);
            S_DRAIN:  drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
            S_OUTPUT: done_d = result_ready;
            default:  ;
        endcase
    end

    always_comb begin
        reset_accumulated_spikes = (state_q == S_CLEAR);
        ts_req                   = (state_q == S_RUN);
        busy                     = (state_q != S_IDLE);
        result_valid             = (state_q == S_OUTPUT);
        threshold                = threshold_q;
        ts_index                 = ts_index_q;
        done                     = done_q;
    end

endmodule
